// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
//   Latches hall and car calls for a single elevator car and picks the car's
//   next action with a SCAN (collective) policy. One command at a time is
//   offered to the car sequencing FSM over a valid/ack handshake, and
//   serviced calls are dropped when the car reports a door-open at a floor.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   power      0 clears pending calls, withdraws any command, forces dir IDLE
//   upcall     hall up buttons (top floor ignored), level-sampled
//   downcall   hall down buttons (floor 0 ignored), level-sampled
//   floor_btn  in-car buttons, level-sampled
//   cur_floor  current car floor; values >= FLOORS are treated as invalid
//   car_idle   car stopped, doors closed, waiting for a command
//   serve      1-cycle pulse: doors opened at cur_floor
//   cmd_ack    car accepts the current command
//   cmd_valid  command offered
//   cmd        00 NONE, 01 OPEN, 10 MOVE_UP, 11 MOVE_DOWN
//   dir        00 IDLE, 01 UP, 10 DOWN
//   up_pend / down_pend / car_pend  registered pending call vectors
//
// State (dir register)
//   state    | meaning
//   DIR_IDLE | no sweep in progress; nearest call chooses the sweep
//   DIR_UP   | sweeping upward, serving up calls and car calls on the way
//   DIR_DOWN | sweeping downward, serving down calls and car calls on the way
module elevator_call_scheduler #(
  parameter int FLOORS = 8,
  parameter int FW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic [FLOORS-1:0] upcall,
  input  logic [FLOORS-1:0] downcall,
  input  logic [FLOORS-1:0] floor_btn,
  input  logic [FW-1:0]     cur_floor,
  input  logic              car_idle,
  input  logic              serve,
  input  logic              cmd_ack,
  output logic              cmd_valid,
  output logic [1:0]        cmd,
  output logic [1:0]        dir,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] down_pend,
  output logic [FLOORS-1:0] car_pend
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'b00,
    CMD_OPEN      = 2'b01,
    CMD_MOVE_UP   = 2'b10,
    CMD_MOVE_DOWN = 2'b11
  } cmd_t;

  // No up button on the top floor, no down button on the ground floor.
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  dir_t              dir_q, dir_d;
  cmd_t              cmd_q, cmd_d;
  logic              valid_q, valid_d;
  logic              armed_q, armed_d;
  logic [FLOORS-1:0] up_q, up_d, dn_q, dn_d, car_q, car_d;

  logic              floor_ok;
  logic [FLOORS-1:0] at_f, above_m, below_m, any_pend;
  logic              above, below, here_up, here_dn, here_car;
  int                dist_up, dist_dn;

  logic              eval;
  logic              issue;
  cmd_t              cmd_new;
  dir_t              dir_new;
  logic [FLOORS-1:0] clr_up, clr_dn, clr_car;

  assign floor_ok = int'(cur_floor) < FLOORS;
  assign any_pend = up_q | dn_q | car_q;

  // Floor-relative masks and distance to the closest call on each side.
  always_comb begin
    at_f    = '0;
    above_m = '0;
    below_m = '0;
    dist_up = FLOORS;
    dist_dn = FLOORS;
    for (int i = 0; i < FLOORS; i++) begin
      at_f[i]    = (int'(cur_floor) == i);
      above_m[i] = (i > int'(cur_floor));
      below_m[i] = (i < int'(cur_floor));
    end
    // Descending scan leaves the lowest floor above; ascending scan leaves
    // the highest floor below.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (any_pend[i] && above_m[i]) dist_up = i - int'(cur_floor);
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (any_pend[i] && below_m[i]) dist_dn = int'(cur_floor) - i;
    end
  end

  assign above    = |(any_pend & above_m);
  assign below    = |(any_pend & below_m);
  assign here_up  = |(up_q & at_f);
  assign here_dn  = |(dn_q & at_f);
  assign here_car = |(car_q & at_f);

  // SCAN decision from the registered call state.
  always_comb begin
    issue   = 1'b0;
    cmd_new = CMD_NONE;
    dir_new = dir_q;
    case (dir_q)
      DIR_UP: begin
        if (here_up || here_car) begin
          issue = 1'b1; cmd_new = CMD_OPEN;
        end else if (above) begin
          issue = 1'b1; cmd_new = CMD_MOVE_UP;
        end else if (here_dn) begin
          issue = 1'b1; cmd_new = CMD_OPEN; dir_new = DIR_DOWN;
        end else if (below) begin
          issue = 1'b1; cmd_new = CMD_MOVE_DOWN; dir_new = DIR_DOWN;
        end else begin
          dir_new = DIR_IDLE;
        end
      end
      DIR_DOWN: begin
        if (here_dn || here_car) begin
          issue = 1'b1; cmd_new = CMD_OPEN;
        end else if (below) begin
          issue = 1'b1; cmd_new = CMD_MOVE_DOWN;
        end else if (here_up) begin
          issue = 1'b1; cmd_new = CMD_OPEN; dir_new = DIR_UP;
        end else if (above) begin
          issue = 1'b1; cmd_new = CMD_MOVE_UP; dir_new = DIR_UP;
        end else begin
          dir_new = DIR_IDLE;
        end
      end
      default: begin
        dir_new = DIR_IDLE;
        if (here_up || here_dn || here_car) begin
          issue = 1'b1; cmd_new = CMD_OPEN;
        end else if (above && (!below || dist_up <= dist_dn)) begin
          // Ties go upward.
          issue = 1'b1; cmd_new = CMD_MOVE_UP; dir_new = DIR_UP;
        end else if (below) begin
          issue = 1'b1; cmd_new = CMD_MOVE_DOWN; dir_new = DIR_DOWN;
        end
      end
    endcase
  end

  // Serve clears the car call and the hall call in the sweep direction. The
  // opposite hall call is also taken when the sweep is about to reverse here.
  always_comb begin
    clr_up  = '0;
    clr_dn  = '0;
    clr_car = '0;
    if (serve && floor_ok) begin
      clr_car = at_f;
      case (dir_q)
        DIR_UP: begin
          clr_up = at_f;
          if (!above) clr_dn = at_f;
        end
        DIR_DOWN: begin
          clr_dn = at_f;
          if (!below) clr_up = at_f;
        end
        default: begin
          clr_up = at_f;
          clr_dn = at_f;
        end
      endcase
    end
  end

  assign eval = car_idle && armed_q && !valid_q && power && floor_ok;

  always_comb begin
    dir_d   = dir_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    armed_d = armed_q;
    up_d    = ((up_q  | (upcall   & UP_MASK)) & ~clr_up)  & UP_MASK;
    dn_d    = ((dn_q  | (downcall & DN_MASK)) & ~clr_dn)  & DN_MASK;
    car_d   =  (car_q | floor_btn)            & ~clr_car;
    if (!power) begin
      dir_d   = DIR_IDLE;
      cmd_d   = CMD_NONE;
      valid_d = 1'b0;
      up_d    = '0;
      dn_d    = '0;
      car_d   = '0;
    end else begin
      // Moving car re-arms, so each idle period yields one command.
      if (!car_idle) armed_d = 1'b1;
      if (valid_q && cmd_ack) begin
        valid_d = 1'b0;
        cmd_d   = CMD_NONE;
        armed_d = 1'b0;
      end else if (eval) begin
        dir_d = dir_new;
        if (issue) begin
          valid_d = 1'b1;
          cmd_d   = cmd_new;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= DIR_IDLE;
      cmd_q   <= CMD_NONE;
      valid_q <= 1'b0;
      armed_q <= 1'b1;
      up_q    <= '0;
      dn_q    <= '0;
      car_q   <= '0;
    end else begin
      dir_q   <= dir_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      car_q   <= car_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd       = cmd_q;
  assign dir       = dir_q;
  assign up_pend   = up_q;
  assign down_pend = dn_q;
  assign car_pend  = car_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: directed scenarios followed by
// random car/button traffic, all checked against a call-list reference model.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst, power, car_idle, serve, cmd_ack;
  logic [7:0] upcall, downcall, floor_btn;
  logic [3:0] cur_floor;
  logic       cmd_valid;
  logic [1:0] cmd, dir;
  logic [7:0] up_pend, down_pend, car_pend;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.FLOORS(8), .FW(4)) dut (
    .clk(clk), .rst(rst), .power(power),
    .upcall(upcall), .downcall(downcall), .floor_btn(floor_btn),
    .cur_floor(cur_floor), .car_idle(car_idle), .serve(serve),
    .cmd_ack(cmd_ack), .cmd_valid(cmd_valid), .cmd(cmd), .dir(dir),
    .up_pend(up_pend), .down_pend(down_pend), .car_pend(car_pend)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: call lists per floor, sweep direction 0 idle/1 up/2 down.
  bit [7:0] m_up, m_dn, m_car;
  int       m_dir, m_cmd;
  bit       m_valid, m_armed;
  int       exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit call_at(input int i);
    return m_up[i] | m_dn[i] | m_car[i];
  endfunction

  task automatic decide(input int f, input bit above, input bit below);
    int c;
    c = 0;
    if (m_dir == 1) begin
      if (m_up[f] || m_car[f]) c = 1;
      else if (above) c = 2;
      else if (m_dn[f]) begin c = 1; m_dir = 2; end
      else if (below) begin c = 3; m_dir = 2; end
      else m_dir = 0;
    end else if (m_dir == 2) begin
      if (m_dn[f] || m_car[f]) c = 1;
      else if (below) c = 3;
      else if (m_up[f]) begin c = 1; m_dir = 1; end
      else if (above) begin c = 2; m_dir = 1; end
      else m_dir = 0;
    end else begin
      if (call_at(f)) c = 1;
      else begin
        // Walk outward one floor at a time; upward is looked at first.
        for (int d = 1; d < 8 && c == 0; d++) begin
          if (f + d < 8 && call_at(f + d)) begin c = 2; m_dir = 1; end
          else if (f - d >= 0 && call_at(f - d)) begin c = 3; m_dir = 2; end
        end
      end
    end
    if (c != 0) begin
      m_valid = 1'b1;
      m_cmd   = c;
      exp_q.push_back(c);
    end
  endtask

  task automatic model_step();
    int f;
    bit fv, above, below, na;
    bit [7:0] nu, nd, nc;
    if (rst) begin
      m_up = '0; m_dn = '0; m_car = '0;
      m_dir = 0; m_valid = 0; m_cmd = 0; m_armed = 1;
      return;
    end
    if (!power) begin
      m_up = '0; m_dn = '0; m_car = '0;
      m_dir = 0; m_valid = 0; m_cmd = 0;
      return;
    end
    f = int'(cur_floor);
    fv = (f < 8);
    above = 0; below = 0;
    for (int i = 0; i < 8; i++) begin
      if (call_at(i) && i > f) above = 1;
      if (call_at(i) && i < f) below = 1;
    end
    nu = m_up | (upcall & 8'h7f);
    nd = m_dn | (downcall & 8'hfe);
    nc = m_car | floor_btn;
    if (serve && fv) begin
      nc[f] = 0;
      if (m_dir == 1) begin nu[f] = 0; if (!above) nd[f] = 0; end
      else if (m_dir == 2) begin nd[f] = 0; if (!below) nu[f] = 0; end
      else begin nu[f] = 0; nd[f] = 0; end
    end
    na = m_armed;
    if (!car_idle) na = 1;
    if (m_valid && cmd_ack) begin
      m_valid = 0; m_cmd = 0; na = 0;
    end else if (car_idle && m_armed && !m_valid && fv) begin
      decide(f, above, below);
    end
    m_armed = na;
    m_up = nu; m_dn = nd; m_car = nc;
  endtask

  task automatic check_all();
    chk("cmd_valid", int'(cmd_valid), int'(m_valid));
    chk("cmd", int'(cmd), m_cmd);
    chk("dir", int'(dir), m_dir);
    chk("up_pend", int'(up_pend), int'(m_up));
    chk("down_pend", int'(down_pend), int'(m_dn));
    chk("car_pend", int'(car_pend), int'(m_car));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst = 1; cyc(1); rst = 0;
  endtask

  task automatic ack1();
    cmd_ack = 1; cyc(1); cmd_ack = 0;
  endtask

  // Monitor: every newly offered command is matched against the oldest
  // command the model decided to issue.
  logic prev_v = 1'b0;
  int   mon_e;
  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_scoreboard: got cmd 0x%0h, no command expected", cmd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cmd_scoreboard", int'(cmd), mon_e);
      end
    end
    prev_v = cmd_valid;
  end

  initial begin
    rst = 1; power = 1; car_idle = 1; serve = 0; cmd_ack = 0;
    upcall = 0; downcall = 0; floor_btn = 0; cur_floor = 0;

    // Reset, then a single car call from floor 0.
    do_reset();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_pend", int'({up_pend, down_pend, car_pend}), 0);
    floor_btn = 8'h20; cyc(1); floor_btn = 0;
    chk("btn5_car_pend", int'(car_pend), 8'h20);
    chk("btn5_no_cmd_yet", int'(cmd_valid), 0);
    cyc(1);
    chk("btn5_valid", int'(cmd_valid), 1);
    chk("btn5_move_up", int'(cmd), 2);
    chk("btn5_dir_up", int'(dir), 1);
    cyc(3);
    chk("btn5_hold", int'(cmd_valid), 1);
    ack1();
    chk("btn5_ack_drop", int'(cmd_valid), 0);
    cyc(3);
    chk("no_second_cmd", int'(cmd_valid), 0);
    car_idle = 0; cyc(1); car_idle = 1; cyc(1);
    chk("rearm_cmd", int'(cmd_valid), 1);
    ack1();

    // Sweeping up at floor 3 with calls both ways here and a car call above.
    do_reset();
    cur_floor = 3; floor_btn = 8'h40; cyc(1); floor_btn = 0; cyc(1);
    ack1();
    car_idle = 0; upcall = 8'h08; downcall = 8'h08; cyc(1);
    upcall = 0; downcall = 0; car_idle = 1; cyc(1);
    chk("up3_open", int'(cmd), 1);
    chk("up3_dir", int'(dir), 1);
    ack1();
    car_idle = 0; serve = 1; cyc(1); serve = 0;
    chk("up3_serve_up", int'(up_pend), 0);
    chk("up3_serve_down_kept", int'(down_pend), 8'h08);

    // Nothing above floor 3: serve takes both, then sweep reverses.
    cur_floor = 6; serve = 1; cyc(1); serve = 0;
    cur_floor = 3; upcall = 8'h08; floor_btn = 8'h02; cyc(1);
    upcall = 0; floor_btn = 0; car_idle = 1; cyc(1);
    chk("rev_open", int'(cmd), 1);
    ack1();
    car_idle = 0; serve = 1; cyc(1); serve = 0;
    chk("rev_clear_up", int'(up_pend), 0);
    chk("rev_clear_down", int'(down_pend), 0);
    car_idle = 1; cyc(1);
    chk("rev_move_down", int'(cmd), 3);
    chk("rev_dir_down", int'(dir), 2);
    ack1();

    // Idle at floor 4: nearest call wins, tie goes up.
    do_reset();
    cur_floor = 4; car_idle = 0; floor_btn = 8'h42; cyc(1);
    floor_btn = 0; car_idle = 1; cyc(1);
    chk("near_up", int'(cmd), 2);
    ack1();
    do_reset();
    car_idle = 0; floor_btn = 8'h44; cyc(1);
    floor_btn = 0; car_idle = 1; cyc(1);
    chk("tie_up", int'(cmd), 2);
    ack1();

    // Clear beats same-cycle press; masked hall buttons.
    do_reset();
    cur_floor = 2; car_idle = 0; floor_btn = 8'h04; cyc(1);
    serve = 1; cyc(1); serve = 0; floor_btn = 0;
    chk("clr_wins", int'(car_pend), 0);
    upcall = 8'h80; downcall = 8'h01; cyc(1); upcall = 0; downcall = 0;
    chk("mask_up7", int'(up_pend), 0);
    chk("mask_dn0", int'(down_pend), 0);

    // Power loss mid-handshake.
    do_reset();
    cur_floor = 0; car_idle = 0; floor_btn = 8'h20; cyc(1);
    floor_btn = 0; car_idle = 1; cyc(1);
    chk("pwr_pre_valid", int'(cmd_valid), 1);
    power = 0; cyc(1);
    chk("pwr_valid_drop", int'(cmd_valid), 0);
    chk("pwr_pend_clear", int'(car_pend), 0);
    power = 1; ack1();
    chk("pwr_late_ack", int'(cmd_valid), 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      power = ($urandom_range(0, 59) != 0);
      upcall    = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      downcall  = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      floor_btn = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 5) == 0)
        cur_floor = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(8, 15))
                                                 : 4'($urandom_range(0, 7));
      if (!power) car_idle = 1;
      else if ($urandom_range(0, 3) == 0) car_idle = ~car_idle;
      serve = ($urandom_range(0, 4) == 0);
      cmd_ack = car_idle && power && ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    rst = 0; power = 1; cmd_ack = 0; serve = 0;
    upcall = 0; downcall = 0; floor_btn = 0;
    cyc(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
